// File: rtl/n_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package n_bit_serial_subtractor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bit counter must be able to hold 0..N.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow-out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: Out = {borrow, A - B - B_In}, one bit per clock, LSB first,
// with a start/done handshake and back-to-back restart from the DONE cycle.
module n_bit_serial_subtractor
  import n_bit_serial_subtractor_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         Clk,
  input  logic         Rst_N,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         B_In,
  output logic         Busy,
  output logic         Done,
  output logic [N:0]   Out
);

  localparam int unsigned CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_q, state_n;
  logic [N-1:0]    a_q, a_n;
  logic [N-1:0]    b_q, b_n;
  logic [N-1:0]    res_q, res_n;
  logic            borrow_q, borrow_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [N:0]      out_q, out_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;

  logic            d_c;
  logic            bout_c;
  logic [N-1:0]    res_shift_c;

  full_subtractor_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_c),
    .bout (bout_c)
  );

  // New difference bit enters at the MSB so the LSB ends up at bit 0 after N shifts.
  assign res_shift_c = N'({d_c, res_q} >> 1);

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      a_q      <= a_n;
      b_q      <= b_n;
      res_q    <= res_n;
      borrow_q <= borrow_n;
      cnt_q    <= cnt_n;
      out_q    <= out_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    a_n      = a_q;
    b_n      = b_q;
    res_n    = res_q;
    borrow_n = borrow_q;
    cnt_n    = cnt_q;
    out_n    = out_q;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          a_n      = A;
          b_n      = B;
          borrow_n = B_In;
          cnt_n    = '0;
          busy_n   = 1'b1;
          state_n  = ST_RUN;
        end else begin
          state_n  = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_n      = a_q >> 1;
        b_n      = b_q >> 1;
        res_n    = res_shift_c;
        borrow_n = bout_c;
        cnt_n    = cnt_q + CW'(1);
        busy_n   = 1'b1;
        if (cnt_q == LAST) begin
          out_n   = {bout_c, res_shift_c};
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_DONE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Out  = out_q;

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor at N=8.
module tb_n_bit_serial_subtractor;

  localparam int unsigned N = 8;

  logic         Clk;
  logic         Rst_N;
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         B_In;
  logic         Busy;
  logic         Done;
  logic [N:0]   Out;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [8:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  n_bit_serial_subtractor #(.N(N)) dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .Start (Start),
    .A     (A),
    .B     (B),
    .B_In  (B_In),
    .Busy  (Busy),
    .Done  (Done),
    .Out   (Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Starts one operation just after a negedge and waits (bounded) for Done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [8:0] got, output int lat, output int busy_cnt);
    A = a; B = b; B_In = bin; Start = 1'b1;
    lat = 0; busy_cnt = 0;
    do begin
      @(negedge Clk);
      Start = 1'b0;
      lat++;
      if (Busy) busy_cnt++;
    end while (!Done && lat < 40);
    got = Out;
  endtask

  initial begin
    logic [8:0] got;
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic       rbin;
    int         lat, busy_cnt, dones, last_done;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 9'h002};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 9'h1FE};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 9'h1FF};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 9'h0FF};
    vecs[4] = '{8'h00, 8'h01, 1'b0, 9'h1FF};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[6] = '{8'h80, 8'h7F, 1'b0, 9'h001};

    Rst_N = 1'b0; Start = 1'b0; A = '0; B = '0; B_In = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset_out",  32'(Out),  32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_done", 32'(Done), 32'h0);
    Rst_N = 1'b1;
    @(negedge Clk);

    // Directed vectors, back-to-back through the DONE cycle.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, got, lat, busy_cnt);
      chk($sformatf("vec%0d_out", i), 32'(got), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      if (i == 0) chk("vec0_busy_cycles", 32'(busy_cnt), 32'd8);
    end
    @(negedge Clk);
    chk("done_single_pulse", 32'(Done), 32'h0);
    chk("out_holds_after_done", 32'(Out), 32'h001);

    // Start held high: back-to-back results; operands scrambled while busy.
    Start = 1'b1; A = 8'h10; B = 8'h01; B_In = 1'b0;
    dones = 0; last_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (Done) begin
        dones++;
        chk($sformatf("hold_out%0d", dones), 32'(Out), 32'h00F);
        chk($sformatf("hold_gap%0d", dones), 32'(i - last_done), 32'd9);
        last_done = i;
      end
      Start = (i < 20);
      if (Busy) begin
        A = 8'($urandom); B = 8'($urandom); B_In = 1'($urandom);
      end else begin
        A = 8'h10; B = 8'h01; B_In = 1'b0;
      end
    end
    chk("hold_done_count", 32'(dones), 32'd3);

    // Start pulsed while busy is ignored.
    Start = 1'b1; A = 8'hAA; B = 8'h55; B_In = 1'b0;
    dones = 0; got = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (i == 3) begin
        Start = 1'b1; A = 8'h00; B = 8'h01;
      end
      if (Done) begin
        dones++;
        got = Out;
      end
    end
    chk("ignore_out", 32'(got), 32'h055);
    chk("ignore_done_count", 32'(dones), 32'd1);

    // Asynchronous reset mid-operation aborts it.
    Start = 1'b1; A = 8'h80; B = 8'h01; B_In = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    #2 Rst_N = 1'b0;
    #1;
    chk("abort_out",  32'(Out),  32'h0);
    chk("abort_busy", 32'(Busy), 32'h0);
    chk("abort_done", 32'(Done), 32'h0);
    @(negedge Clk);
    Rst_N = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Random operations against an independent golden model.
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      exp = {(10'(ra) < 10'(rb) + 10'(rbin)), 8'(ra - rb - 8'(rbin))};
      run_op(ra, rb, rbin, got, lat, busy_cnt);
      chk($sformatf("rand%0d_a%0h_b%0h_bin%0d", i, ra, rb, rbin), 32'(got), 32'(exp));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/n_bit_serial_subtractor.md
Name: n_bit_serial_subtractor

Overview:
Bit-serial N-bit subtractor that is the inverse of the parallel N-bit adder in the arithmetic library. It computes Out = A - B - B_In one bit per clock, LSB first, using a start/done handshake. Operands and borrow-in are captured on Start. Out has the same N+1-bit shape as the adder output, with the borrow-out in the MSB. It is the area-cheap option for datapaths that can tolerate N+1 cycles of latency.

Parameters:
N, 8, operand width; legal for N >= 1.

Ports:
Clk  input  1  rising-edge clock.
Rst_N  input  1  asynchronous active-low reset.
Start  input  1  request; sampled only when Busy=0.
A  input  N  minuend; captured when Start is accepted.
B  input  N  subtrahend; captured when Start is accepted.
B_In  input  1  borrow-in; captured when Start is accepted.
Busy  output  1  high while a subtraction is in progress.
Done  output  1  one-cycle pulse: Out is valid.
Out  output  N+1  result. Out[N-1:0] = (A - B - B_In) mod 2^N. Out[N] = borrow-out = 1 iff A < B + B_In (unsigned).

Behaviour:
- Interface (already decided): one clock, Clk. Reset Rst_N is asynchronous and active-low.
- Reset values: state=IDLE, Busy=0, Done=0, Out=0, all internal registers=0. Assertion takes effect immediately, with no clock edge needed.
- States:
  - IDLE: Busy=0. Start=1 at an edge → latch A, B; borrow <= B_In; bit_cnt <= 0; go to RUN.
  - RUN: Busy=1. Each edge:
    - d = a0 ^ b0 ^ borrow
    - borrow <= (~a0 & b0) | (~a0 & borrow) | (b0 & borrow)
    - A and B shift right by 1; d shifts into the MSB of the result shift register
    - bit_cnt increments
    - on the edge that processes bit N-1: Out <= {borrow_next, result_next}; Done <= 1; go to DONE.
  - DONE: Busy=0, Done=1 for this single cycle.
    - Start=1 at the next edge → accept a new operation exactly as from IDLE (back-to-back supported); otherwise go to IDLE.
    - Done always drops after one cycle.
- Latency: if Start is accepted at edge k, Done is high in the cycle after edge k+N. Throughput is one result per N+1 cycles with back-to-back Start.
- Out holds its value until the next Done. It does not change during RUN. A new Start does not clear it.
- Start while Busy=1 is ignored; the operation in progress is unaffected. A, B and B_In are don't-care outside the accepting edge.
- Reset during RUN aborts the operation: no Done, Out=0, back to IDLE.
- Wrap-around: 0 - 1 gives Out = {1, all-ones}. The borrow chain crosses all N bits with no saturation.
- N=1: RUN lasts exactly one edge, so Done comes 2 cycles after Start.
- bit_cnt width is $clog2(N+1). Internal shift registers are N bits wide.

Decomposition:
- Shared arithmetic package holds:
  - the state enum {IDLE, RUN, DONE} (2-bit encoding);
  - a function computing the counter width, clog2(N+1).
- One natural sub-module: full_subtractor_cell, a combinational 1-bit cell with inputs a, b, bin and outputs d, bout. It is instantiated once in the serial loop and can be reused by a future parallel subtractor.
- The FSM, counter and shift registers stay in the top module.

Test Plan (N=8):
1. A=0x05, B=0x03, B_In=0, Start one cycle → Busy high for 8 cycles, Done high in the 9th cycle after the Start edge, Out=9'h002.
2. A=0x03, B=0x05, B_In=0 → Out=9'h1FE. Then A=0x00, B=0x00, B_In=1 → Out=9'h1FF. Then A=0xFF, B=0x00, B_In=0 → Out=9'h0FF.
3. Start held high for 20 cycles with A=0x10, B=0x01 → back-to-back results 9'h00F with exactly 9 cycles between Done pulses. Operand changes driven while Busy=1 do not affect the result.
4. Start with A=0xAA, B=0x55. Pulse Start again at cycle 3 with A=0x00, B=0x01 → the second Start is ignored, Out=9'h055, and only one Done is seen.
5. Start with A=0x80, B=0x01. Assert Rst_N=0 at cycle 4 between clock edges → Out=0, Busy=0, Done=0 immediately, and no Done follows after release.
6. 50 random {A, B, B_In} operations, each waiting for Done → Out must equal the golden model {A < B+B_In, (A-B-B_In)[7:0]} every time.
